fpu_ss_multi_scoreboard: RTL and testbench

// - Per-core FP register scoreboard for the FPU subsystem; replaces the single-bit rd scoreboard with per-register pending-write counters.
// - Counters cover NB_CORES register banks and allow several outstanding writes to one register.
// - Sits between input-buffer pop and FPnew/LSU dispatch: gates dispatch on RAW, WAW and capacity hazards and selects writeback forwarding.
// - Tracks FPnew and memory-result writebacks independently.

---
 rtl/fpu_ss_multi_scoreboard.sv | 121 ++++++++++++
 tb/tb_fpu_ss_multi_scoreboard.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_ss_multi_scoreboard.sv
// Per-core FP register scoreboard with per-register pending-write counters.
// Optional writeback forwarding is enabled by defining FPU_SS_SB_FWD_EN.
module fpu_ss_multi_scoreboard #(
    parameter int NB_CORES     = 8,
    parameter int NUM_REGS     = 32,
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = 8,
    parameter int IN_ORDER_WB  = 0,
    localparam int CORE_W      = (NB_CORES > 1) ? $clog2(NB_CORES) : 1,
    localparam int REG_W       = $clog2(NUM_REGS),
    localparam int INF_W       = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                disp_valid_i,
    output logic                disp_ready_o,
    input  logic [CORE_W-1:0]   disp_core_i,
    input  logic [3*REG_W-1:0]  disp_rs_i,
    input  logic [2:0]          disp_rs_use_i,
    input  logic [REG_W-1:0]    disp_rd_i,
    input  logic                disp_rd_fp_i,
    input  logic                fpu_wb_valid_i,
    input  logic [CORE_W-1:0]   fpu_wb_core_i,
    input  logic [REG_W-1:0]    fpu_wb_rd_i,
    input  logic                lsu_wb_valid_i,
    input  logic [CORE_W-1:0]   lsu_wb_core_i,
    input  logic [REG_W-1:0]    lsu_wb_rd_i,
    output logic [5:0]          fwd_sel_o,
    output logic [INF_W-1:0]    inflight_o,
    output logic                err_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [INF_W-1:0] INF_MAX = INF_W'(MAX_INFLIGHT);

    logic [CNT_W-1:0] cnt [NB_CORES][NUM_REGS];
    logic [INF_W-1:0] inflight_q;
    logic             err_q;

    logic [REG_W-1:0] rs_addr [3];
    logic [CNT_W-1:0] rs_cnt  [3];
    logic [2:0]       raw_haz;
    logic [5:0]       fwd_sel;
`ifdef FPU_SS_SB_FWD_EN
    logic [2:0]       rs_fpu_hit;
    logic [2:0]       rs_lsu_hit;
`endif
    logic [CNT_W-1:0] rd_cnt, fpu_cnt, lsu_cnt;
    logic             hazard, inc, same_tgt, fpu_ok, lsu_ok, err_set;

    always_comb begin
        raw_haz = '0;
        fwd_sel = '0;
`ifdef FPU_SS_SB_FWD_EN
        rs_fpu_hit = '0;
        rs_lsu_hit = '0;
`endif
        for (int i = 0; i < 3; i++) begin
            rs_addr[i] = disp_rs_i[i*REG_W +: REG_W];
            rs_cnt[i]  = cnt[disp_core_i][rs_addr[i]];
`ifdef FPU_SS_SB_FWD_EN
            rs_fpu_hit[i] = fpu_wb_valid_i && (fpu_wb_core_i == disp_core_i) && (fpu_wb_rd_i == rs_addr[i]);
            rs_lsu_hit[i] = lsu_wb_valid_i && (lsu_wb_core_i == disp_core_i) && (lsu_wb_rd_i == rs_addr[i]);
            // Only the last outstanding write can be forwarded, and only from a single source
            if (disp_rs_use_i[i] && (rs_cnt[i] != '0)) begin
                if ((rs_cnt[i] == CNT_W'(1)) && (rs_fpu_hit[i] ^ rs_lsu_hit[i]))
                    fwd_sel[2*i +: 2] = rs_fpu_hit[i] ? 2'b01 : 2'b10;
                else
                    raw_haz[i] = 1'b1;
            end
`else
            if (disp_rs_use_i[i] && (rs_cnt[i] != '0))
                raw_haz[i] = 1'b1;
`endif
        end
    end

    always_comb begin
        rd_cnt  = cnt[disp_core_i][disp_rd_i];
        hazard  = (|raw_haz)
               || (disp_rd_fp_i && (((IN_ORDER_WB == 0) && (rd_cnt != '0))
                                    || (rd_cnt == CNT_MAX)
                                    || (inflight_q == INF_MAX)));
        inc     = disp_valid_i && !hazard && disp_rd_fp_i;

        // Writebacks see the count before this cycle's dispatch increment
        fpu_cnt  = cnt[fpu_wb_core_i][fpu_wb_rd_i];
        lsu_cnt  = cnt[lsu_wb_core_i][lsu_wb_rd_i];
        same_tgt = fpu_wb_valid_i && lsu_wb_valid_i
                && (fpu_wb_core_i == lsu_wb_core_i) && (fpu_wb_rd_i == lsu_wb_rd_i);
        fpu_ok   = fpu_wb_valid_i && (fpu_cnt != '0);
        lsu_ok   = lsu_wb_valid_i && (same_tgt ? (fpu_cnt > CNT_W'(1)) : (lsu_cnt != '0));
        err_set  = (fpu_wb_valid_i && !fpu_ok) || (lsu_wb_valid_i && !lsu_ok);
    end

    assign disp_ready_o = !hazard;
    assign fwd_sel_o    = fwd_sel;
    assign inflight_o   = inflight_q;
    assign err_o        = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NB_CORES; c++)
                for (int r = 0; r < NUM_REGS; r++)
                    cnt[c][r] <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            for (int c = 0; c < NB_CORES; c++)
                for (int r = 0; r < NUM_REGS; r++)
                    cnt[c][r] <= cnt[c][r]
                        + CNT_W'(inc    && (disp_core_i   == CORE_W'(c)) && (disp_rd_i   == REG_W'(r)))
                        - CNT_W'(fpu_ok && (fpu_wb_core_i == CORE_W'(c)) && (fpu_wb_rd_i == REG_W'(r)))
                        - CNT_W'(lsu_ok && (lsu_wb_core_i == CORE_W'(c)) && (lsu_wb_rd_i == REG_W'(r)));
            inflight_q <= inflight_q + INF_W'(inc) - INF_W'(fpu_ok) - INF_W'(lsu_ok);
            if (err_set)
                err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fpu_ss_multi_scoreboard.sv
// Bench for fpu_ss_multi_scoreboard: two instances (IN_ORDER_WB=0 and 1) share stimulus
// and are checked every cycle against a queue-free counter model, plus directed literals.
module tb_fpu_ss_multi_scoreboard;

    localparam int NB   = 8;
    localparam int NR   = 32;
    localparam int CMAX = 3;
    localparam int MAXI = 8;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        disp_valid;
    logic [2:0]  disp_core;
    logic [14:0] disp_rs;
    logic [2:0]  disp_rs_use;
    logic [4:0]  disp_rd;
    logic        disp_rd_fp;
    logic        fpu_v, lsu_v;
    logic [2:0]  fpu_c, lsu_c;
    logic [4:0]  fpu_r, lsu_r;
    logic        rdy [2];
    logic [5:0]  fwd [2];
    logic [3:0]  inf [2];
    logic        err [2];

    int checks = 0;
    int errors = 0;

    int mcnt [2][NB][NR];
    int minf [2];
    int merr [2];
    logic       er;
    logic [5:0] ef;

    always #5 clk = ~clk;

    fpu_ss_multi_scoreboard #(.NB_CORES(NB), .NUM_REGS(NR), .CNT_W(2), .MAX_INFLIGHT(MAXI), .IN_ORDER_WB(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_ni), .disp_valid_i(disp_valid), .disp_ready_o(rdy[0]),
        .disp_core_i(disp_core), .disp_rs_i(disp_rs), .disp_rs_use_i(disp_rs_use), .disp_rd_i(disp_rd),
        .disp_rd_fp_i(disp_rd_fp), .fpu_wb_valid_i(fpu_v), .fpu_wb_core_i(fpu_c), .fpu_wb_rd_i(fpu_r),
        .lsu_wb_valid_i(lsu_v), .lsu_wb_core_i(lsu_c), .lsu_wb_rd_i(lsu_r),
        .fwd_sel_o(fwd[0]), .inflight_o(inf[0]), .err_o(err[0]));

    fpu_ss_multi_scoreboard #(.NB_CORES(NB), .NUM_REGS(NR), .CNT_W(2), .MAX_INFLIGHT(MAXI), .IN_ORDER_WB(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_ni), .disp_valid_i(disp_valid), .disp_ready_o(rdy[1]),
        .disp_core_i(disp_core), .disp_rs_i(disp_rs), .disp_rs_use_i(disp_rs_use), .disp_rd_i(disp_rd),
        .disp_rd_fp_i(disp_rd_fp), .fpu_wb_valid_i(fpu_v), .fpu_wb_core_i(fpu_c), .fpu_wb_rd_i(fpu_r),
        .lsu_wb_valid_i(lsu_v), .lsu_wb_core_i(lsu_c), .lsu_wb_rd_i(lsu_r),
        .fwd_sel_o(fwd[1]), .inflight_o(inf[1]), .err_o(err[1]));

    task automatic chk(input string name, input int k, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[inst%0d] t=%0t: got %0h, expected %0h", name, k, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < NB; c++)
                for (int r = 0; r < NR; r++)
                    mcnt[k][c][r] = 0;
            minf[k] = 0;
            merr[k] = 0;
        end
    endfunction

    // Expected ready / forwarding select from the hazard rules
    function automatic void model_out(input int k, output logic r, output logic [5:0] f);
        int c, rs;
        c = int'(disp_core);
        r = 1'b1;
        f = '0;
        for (int i = 0; i < 3; i++) begin
            rs = int'(disp_rs[i*5 +: 5]);
            if (disp_rs_use[i] && mcnt[k][c][rs] > 0) begin
`ifdef FPU_SS_SB_FWD_EN
                bit fh, lh;
                fh = fpu_v && (fpu_c == disp_core) && (int'(fpu_r) == rs);
                lh = lsu_v && (lsu_c == disp_core) && (int'(lsu_r) == rs);
                if (mcnt[k][c][rs] == 1 && (fh != lh))
                    f[2*i +: 2] = fh ? 2'b01 : 2'b10;
                else
                    r = 1'b0;
`else
                r = 1'b0;
`endif
            end
        end
        if (disp_rd_fp) begin
            if (k == 0 && mcnt[k][c][disp_rd] > 0) r = 1'b0;
            if (mcnt[k][c][disp_rd] == CMAX) r = 1'b0;
            if (minf[k] == MAXI) r = 1'b0;
        end
    endfunction

    // Writebacks are applied one at a time against pre-dispatch counts, then the dispatch
    function automatic void model_step(input int k, input logic r);
        if (fpu_v) begin
            if (mcnt[k][fpu_c][fpu_r] > 0) begin mcnt[k][fpu_c][fpu_r]--; minf[k]--; end
            else merr[k] = 1;
        end
        if (lsu_v) begin
            if (mcnt[k][lsu_c][lsu_r] > 0) begin mcnt[k][lsu_c][lsu_r]--; minf[k]--; end
            else merr[k] = 1;
        end
        if (disp_valid && r && disp_rd_fp) begin
            mcnt[k][disp_core][disp_rd]++;
            minf[k]++;
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_ni) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                model_out(k, er, ef);
                chk("ready",    k, 32'(rdy[k]), int'(er));
                chk("fwd_sel",  k, 32'(fwd[k]), int'(ef));
                chk("inflight", k, 32'(inf[k]), minf[k]);
                chk("err",      k, 32'(err[k]), merr[k]);
                model_step(k, er);
            end
        end
    end

    task automatic idle();
        disp_valid = 0; disp_core = 0; disp_rs = 0; disp_rs_use = 0; disp_rd = 0; disp_rd_fp = 0;
        fpu_v = 0; fpu_c = 0; fpu_r = 0; lsu_v = 0; lsu_c = 0; lsu_r = 0;
    endtask

    task automatic disp(input int c, input int s0, input int s1, input int s2, input int use_m,
                        input int rd, input int fp);
        disp_valid = 1; disp_core = 3'(c); disp_rs = {5'(s2), 5'(s1), 5'(s0)};
        disp_rs_use = 3'(use_m); disp_rd = 5'(rd); disp_rd_fp = 1'(fp);
    endtask

    task automatic fpu_wb(input int c, input int r);
        fpu_v = 1; fpu_c = 3'(c); fpu_r = 5'(r);
    endtask

    task automatic lsu_wb(input int c, input int r);
        lsu_v = 1; lsu_c = 3'(c); lsu_r = 5'(r);
    endtask

    task automatic nxt(); @(posedge clk); #1; endtask
    task automatic neg(); @(negedge clk); #1; endtask

    // -1 marks a don't-care field
    task automatic exp_out(input string tag, input int k, input int e_rdy, input int e_fwd,
                           input int e_inf, input int e_err);
        if (e_rdy >= 0) chk({tag, "_ready"},    k, 32'(rdy[k]), e_rdy);
        if (e_fwd >= 0) chk({tag, "_fwd"},      k, 32'(fwd[k]), e_fwd);
        if (e_inf >= 0) chk({tag, "_inflight"}, k, 32'(inf[k]), e_inf);
        if (e_err >= 0) chk({tag, "_err"},      k, 32'(err[k]), e_err);
    endtask

    initial begin
        rst_ni = 0;
        idle();
        nxt(); neg();
        for (int k = 0; k < 2; k++) exp_out("reset", k, 1, 0, 0, 0);
        nxt(); rst_ni = 1;

        // RAW on a pending register, released by the FPU writeback
        disp(0, 0, 0, 0, 0, 3, 1);
        neg(); for (int k = 0; k < 2; k++) exp_out("first_disp", k, 1, -1, 0, -1);
        chk("model_cnt03", 0, 32'(mcnt[0][0][3]), 1);
        nxt();
        disp(0, 3, 0, 0, 3'b001, 0, 0);
        neg(); for (int k = 0; k < 2; k++) exp_out("raw", k, 0, 0, 1, -1);
        nxt();
        fpu_wb(0, 3);
        neg();
`ifdef FPU_SS_SB_FWD_EN
        for (int k = 0; k < 2; k++) exp_out("fwd_fpu", k, 1, 6'b000001, 1, -1);
`else
        for (int k = 0; k < 2; k++) exp_out("nofwd_fpu", k, 0, 0, 1, -1);
`endif
        nxt(); fpu_v = 0;
        neg(); for (int k = 0; k < 2; k++) exp_out("raw_clear", k, 1, 0, 0, -1);
        nxt();

        // LSU forwarding on operand rs2
        idle(); disp(2, 0, 0, 0, 0, 5, 1);
        neg(); nxt();
        disp(2, 0, 5, 0, 3'b010, 0, 0); lsu_wb(2, 5);
        neg();
`ifdef FPU_SS_SB_FWD_EN
        for (int k = 0; k < 2; k++) exp_out("fwd_lsu", k, 1, 6'b001000, -1, -1);
`else
        for (int k = 0; k < 2; k++) exp_out("nofwd_lsu", k, 0, 0, -1, -1);
`endif
        nxt(); idle();

        // Core isolation
        disp(1, 0, 0, 0, 0, 7, 1);
        neg(); nxt();
        disp(4, 7, 0, 0, 3'b001, 0, 0);
        neg(); for (int k = 0; k < 2; k++) exp_out("isolation", k, 1, 0, 1, -1);
        nxt(); idle(); lsu_wb(1, 7);
        neg(); nxt(); idle();
        neg(); for (int k = 0; k < 2; k++) exp_out("drained", k, 1, 0, 0, 0);
        nxt();

        // WAW vs in-order writeback, and counter saturation
        disp(0, 0, 0, 0, 0, 1, 1);
        neg(); for (int k = 0; k < 2; k++) exp_out("waw1", k, 1, -1, -1, -1);
        nxt();
        neg(); exp_out("waw2", 0, 0, -1, 1, -1); exp_out("waw2", 1, 1, -1, 1, -1);
        nxt();
        neg(); exp_out("waw3", 0, 0, -1, 1, -1); exp_out("waw3", 1, 1, -1, 2, -1);
        nxt();
        neg(); exp_out("sat", 0, 0, -1, 1, -1); exp_out("sat", 1, 0, -1, 3, -1);
        chk("model_cnt01", 1, 32'(mcnt[1][0][1]), 3);
        nxt();
        idle(); fpu_wb(0, 1); lsu_wb(0, 1);
        neg(); nxt();
        idle(); disp(0, 0, 0, 0, 0, 1, 1);
        neg(); exp_out("dual_wb", 0, 1, -1, 0, 1); exp_out("dual_wb", 1, 1, -1, 1, 0);
        nxt();

        idle(); rst_ni = 0;
        neg(); for (int k = 0; k < 2; k++) exp_out("reset2", k, 1, 0, 0, 0);
        nxt(); rst_ni = 1;

        // Capacity limit is not relieved by a same-cycle writeback
        for (int i = 0; i < 8; i++) begin
            disp(3, 0, 0, 0, 0, i, 1);
            neg(); for (int k = 0; k < 2; k++) exp_out("fill", k, 1, -1, i, -1);
            nxt();
        end
        disp(3, 0, 0, 0, 0, 8, 1); fpu_wb(3, 0);
        neg(); for (int k = 0; k < 2; k++) exp_out("cap", k, 0, -1, 8, -1);
        nxt(); fpu_v = 0;
        neg(); for (int k = 0; k < 2; k++) exp_out("cap_after", k, 1, -1, 7, -1);
        nxt();

        // Writeback to an idle register
        idle(); fpu_wb(0, 9);
        neg(); for (int k = 0; k < 2; k++) exp_out("stray_wb", k, -1, -1, 8, 0);
        nxt(); idle();
        neg(); for (int k = 0; k < 2; k++) exp_out("err_set", k, -1, -1, 8, 1);
        #2 rst_ni = 0;
        #1 for (int k = 0; k < 2; k++) exp_out("async_rst", k, 1, 0, 0, 0);
        neg(); nxt(); rst_ni = 1;

        // Randomized traffic on a small register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            if (n % 750 == 749) begin
                idle(); rst_ni = 0;
                neg(); nxt(); rst_ni = 1;
            end
            disp_valid  = ($urandom_range(0, 3) != 0);
            disp_core   = 3'($urandom_range(0, 1));
            disp_rs     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            disp_rs_use = 3'($urandom_range(0, 7));
            disp_rd     = 5'($urandom_range(0, 7));
            disp_rd_fp  = 1'($urandom_range(0, 1));
            fpu_c = 3'($urandom_range(0, 1)); fpu_r = 5'($urandom_range(0, 7));
            lsu_c = 3'($urandom_range(0, 1)); lsu_r = 5'($urandom_range(0, 7));
            fpu_v = (mcnt[0][fpu_c][fpu_r] > 0 && $urandom_range(0, 1) == 1) || ($urandom_range(0, 99) == 0);
            lsu_v = (mcnt[0][lsu_c][lsu_r] > 0 && $urandom_range(0, 1) == 1) || ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 2) == 0) begin
                disp_core = fpu_c;
                disp_rs[4:0] = fpu_r;
                disp_rs[9:5] = lsu_r;
            end
            nxt();
        end

        idle();
        nxt(); nxt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
